frame_tick_counter: RTL and testbench

Parameterised frame-rate generator for the display/game-loop path. It divides the board clock down to a one-cycle tick at a programmable rate. It keeps a modulo-N frame counter advanced by that tick and presents the count in binary and as two BCD digits for the seven-segment decoders. It has enable, synchronous clear and a wrap pulse, and it replaces the fixed 30 Hz divider/counter pair as the timebase for game logic.

---
 rtl/frame_tick_counter.sv | 83 ++++++++
 tb/tb_frame_tick_counter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/frame_tick_counter.sv
// frame_tick_counter: divides the clock to a one-cycle tick at TICK_HZ and
// keeps a modulo-MODULUS frame count in binary plus two incremental BCD digits.
module frame_tick_counter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 30,
    parameter int MODULUS = 30,
    parameter int CNT_W   = 6
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             enable,
    input  logic             clear,
    output logic             tick,
    output logic             wrap,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       bcd_ones,
    output logic [3:0]       bcd_tens
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int P_W = $clog2(DIV);

    logic [P_W-1:0]   p_q, p_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       ones_q, ones_d, tens_q, tens_d;
    logic             tick_q, tick_d, wrap_q, wrap_d;

    always_comb begin
        p_d     = p_q;
        count_d = count_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear) begin
            p_d     = '0;
            count_d = '0;
            ones_d  = '0;
            tens_d  = '0;
        end else if (enable) begin
            if (p_q == P_W'(DIV - 1)) begin
                p_d    = '0;
                tick_d = 1'b1;
                if (count_q == CNT_W'(MODULUS - 1)) begin
                    count_d = '0;
                    ones_d  = '0;
                    tens_d  = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    // BCD follows count digit-wise so no divider is needed
                    ones_d  = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
                    tens_d  = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
                end
            end else begin
                p_d = p_q + P_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            p_q     <= '0;
            count_q <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            p_q     <= p_d;
            count_q <= count_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign count    = count_q;
    assign bcd_ones = ones_q;
    assign bcd_tens = tens_q;
endmodule

// File: tb/tb_frame_tick_counter.sv
// tb_frame_tick_counter: directed scenarios plus random enable/clear/reset,
// checked against an arithmetic model (enabled-cycle and tick totals).
module tb_frame_tick_counter;
    localparam int DIV = 10;
    localparam int MOD = 12;

    logic       CLOCK_50, resetn, enable, clear;
    logic       tick, wrap;
    logic [3:0] count, bcd_ones, bcd_tens;

    int checks = 0;
    int failures = 0;
    int en_cycles = 0;
    int ticks = 0;
    int m_tick = 0;

    frame_tick_counter #(.CLK_HZ(100), .TICK_HZ(10), .MODULUS(MOD), .CNT_W(4)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable), .clear(clear),
        .tick(tick), .wrap(wrap), .count(count), .bcd_ones(bcd_ones), .bcd_tens(bcd_tens)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        en_cycles = 0;
        ticks     = 0;
        m_tick    = 0;
    endtask

    task automatic check_all();
        int c;
        c = ticks % MOD;
        chk("tick", int'(tick), m_tick);
        chk("wrap", int'(wrap), (m_tick == 1 && c == 0) ? 1 : 0);
        chk("count", int'(count), c);
        chk("bcd_ones", int'(bcd_ones), c % 10);
        chk("bcd_tens", int'(bcd_tens), c / 10);
    endtask

    // one rising edge: advance the model from the sampled inputs, then compare
    task automatic cycle();
        @(posedge CLOCK_50);
        if (!resetn) model_reset();
        else if (clear) begin
            en_cycles = 0;
            ticks     = 0;
            m_tick    = 0;
        end else if (enable) begin
            en_cycles++;
            m_tick = (en_cycles % DIV == 0) ? 1 : 0;
            ticks += m_tick;
        end else m_tick = 0;
        #1;
        check_all();
    endtask

    task automatic async_reset();
        resetn = 1'b0;
        #2;
        model_reset();
        check_all();
    endtask

    initial begin
        resetn = 1'b0;
        enable = 1'b1;
        clear  = 1'b0;
        repeat (3) cycle();
        resetn = 1'b1;
        for (int i = 1; i <= 121; i++) begin
            cycle();
            if (i == 9)   chk("pre_first_tick", int'(tick), 0);
            if (i == 10) begin
                chk("first_tick", int'(tick), 1);
                chk("first_count", int'(count), 1);
                chk("first_ones", int'(bcd_ones), 1);
            end
            if (i == 90)  chk("c9_digits", int'({bcd_tens, bcd_ones}), 8'h09);
            if (i == 100) chk("c10_digits", int'({bcd_tens, bcd_ones}), 8'h10);
            if (i == 110) chk("c11_digits", int'({bcd_tens, bcd_ones}), 8'h11);
            if (i == 120) begin
                chk("wrap_tick", int'(tick & wrap), 1);
                chk("wrap_count", int'(count), 0);
            end
            if (i == 121) chk("wrap_single", int'(wrap), 0);
        end
        repeat (3) cycle();
        enable = 1'b0;
        for (int i = 0; i < 25; i++) cycle();
        enable = 1'b1;
        repeat (5) cycle();
        chk("pause_no_early", int'(tick), 0);
        cycle();
        chk("pause_tick", int'(tick), 1);
        chk("pause_count", int'(count), 1);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        repeat (59) cycle();
        chk("pre_clear_count", int'(count), 5);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clear_tick", int'(tick), 0);
        chk("clear_count", int'(count), 0);
        repeat (9) cycle();
        chk("clear_no_early", int'(tick), 0);
        cycle();
        chk("clear_next_tick", int'(tick), 1);
        chk("clear_next_count", int'(count), 1);
        repeat (60) cycle();
        chk("pre_reset_count", int'(count), 7);
        async_reset();
        chk("async_count", int'(count), 0);
        repeat (2) cycle();
        resetn = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 399) == 0) async_reset();
            else resetn = 1'b1;
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
